// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmitter and its matching serial-in receiver.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter over 0..MODULUS-1 with synchronous clear, enable and terminal-count flag.
module piso_bit_counter #(
  parameter int  MODULUS = 8,
  localparam int CW      = $clog2(MODULUS)
) (
  input  logic          i_clk,
  input  logic          i_srst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CW'(MODULUS - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, with frame start/end markers.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Load_Data,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             Data_Out,
  output logic             Data_Valid,
  output logic             Frame_Start,
  output logic             Frame_End
);

  localparam int CNT_W = $clog2(WIDTH);

  piso_state_t      r_state, w_state_next;
  // The bit on Data_Out lives in r_data_out; r_shift holds the bits still to go.
  logic [WIDTH-2:0] r_shift, w_shift_next;
  logic [WIDTH-1:0] w_shift_ext;
  logic             r_data_out, w_data_out_next;
  logic             r_data_valid, w_valid_next;
  logic             r_frame_start, w_start_next;
  logic             r_frame_end, w_end_next;
  logic             w_cnt_clr, w_cnt_en, w_cnt_tc;
  logic [CNT_W-1:0] w_cnt;
  logic             w_load_ready, w_accept;
`ifdef PISO_PARITY_EN
  logic             r_parity, w_parity_next;
`endif

  piso_bit_counter #(.MODULUS(WIDTH)) u_bit_counter (
    .i_clk   (Clock),
    .i_srst  (Rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_cnt),
    .o_tc    (w_cnt_tc)
  );

`ifdef PISO_PARITY_EN
  assign w_load_ready = (r_state == ST_IDLE) || (r_state == ST_PARITY);
`else
  assign w_load_ready = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_cnt_tc);
`endif
  assign w_accept    = Load_Valid && w_load_ready;
  assign w_shift_ext = {r_shift, IDLE_LEVEL};

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_data_out_next = IDLE_LEVEL;
    w_valid_next    = 1'b0;
    w_start_next    = 1'b0;
    w_end_next      = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;
`ifdef PISO_PARITY_EN
    w_parity_next   = r_parity;
`endif
    if (w_accept) begin
      w_state_next    = ST_SHIFT;
      w_shift_next    = Load_Data[WIDTH-2:0];
      w_data_out_next = Load_Data[WIDTH-1];
      w_valid_next    = 1'b1;
      w_start_next    = 1'b1;
      w_cnt_clr       = 1'b1;
`ifdef PISO_PARITY_EN
      w_parity_next   = ^Load_Data;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          w_shift_next = w_shift_ext[WIDTH-2:0];
          if (!w_cnt_tc) begin
            w_data_out_next = w_shift_ext[WIDTH-1];
            w_valid_next    = 1'b1;
            w_cnt_en        = 1'b1;
`ifndef PISO_PARITY_EN
            w_end_next      = (w_cnt == CNT_W'(WIDTH - 2));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            w_state_next    = ST_PARITY;
            w_data_out_next = r_parity;
            w_valid_next    = 1'b1;
            w_end_next      = 1'b1;
`else
            w_state_next    = ST_IDLE;
`endif
          end
        end
        ST_PARITY: w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_data_out    <= IDLE_LEVEL;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_shift       <= w_shift_next;
      r_data_out    <= w_data_out_next;
      r_data_valid  <= w_valid_next;
      r_frame_start <= w_start_next;
      r_frame_end   <= w_end_next;
`ifdef PISO_PARITY_EN
      r_parity      <= w_parity_next;
`endif
    end
  end

  assign Load_Ready  = w_load_ready;
  assign Data_Out    = r_data_out;
  assign Data_Valid  = r_data_valid;
  assign Frame_Start = r_frame_start;
  assign Frame_End   = r_frame_end;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the pixel/descriptor bit-stream path. It is the sending end of the serial-in shift chains used for stream delays and deserialization.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first, one bit per Clock.
- Provides frame markers so the downstream serial-in chain can align words.
- Supports back-to-back frames with zero idle cycles.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- IDLE_LEVEL, 1'b0, value driven on Data_Out when no frame is active.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Rst  input  1  synchronous, active-high reset.
- Load_Data  input  WIDTH  parallel word to transmit.
- Load_Valid  input  1  Load_Data is valid.
- Load_Ready  output  1  block can accept a word this cycle (combinational from state).
- Data_Out  output  1  serial bit, registered.
- Data_Valid  output  1  Data_Out carries a frame bit, registered.
- Frame_Start  output  1  high on the first bit of a frame, registered.
- Frame_End  output  1  high on the final bit of a frame, registered.

Behaviour:
- Reset: Rst is sampled on the rising edge of Clock and takes priority over everything else.
  - State goes to IDLE; shift register, bit counter, Data_Valid, Frame_Start and Frame_End go to 0; Data_Out goes to IDLE_LEVEL.
  - No handshake is accepted in a cycle where Rst is high.
- States:
  - IDLE: no frame active; Load_Ready = 1.
  - SHIFT: transmitting data bits.
  - PARITY: only exists when the optional feature is compiled in.
- Accept: Load_Valid && Load_Ready && !Rst at edge k.
  - Load_Data is captured into the shift register and the bit counter is cleared.
  - The MSB appears on Data_Out during cycle k+1 with Data_Valid = 1 and Frame_Start = 1.
  - Latency is 1 cycle from accept to first bit.
- Shifting: each edge in SHIFT shifts the register left by one, filling with IDLE_LEVEL, and increments the counter.
  - Counter width is $clog2(WIDTH); it counts 0..WIDTH-1 and never wraps inside a frame.
  - Bit i (MSB = i 0) is presented at cycle k+1+i.
- Final cycle: the cycle presenting bit WIDTH-1 (or the parity bit when enabled).
  - Frame_End = 1 and Load_Ready = 1 in that cycle.
- Back-to-back: an accept in the final cycle loads the next word, so its MSB follows at the next cycle with no gap.
  - In that next cycle Frame_Start = 1 and Frame_End = 0.
- Frame completion without a new accept: return to IDLE.
  - Next cycle: Data_Valid = 0, Data_Out = IDLE_LEVEL, Frame_Start = Frame_End = 0.
- Load_Ready = 0 during non-final SHIFT cycles.
  - Load_Valid is ignored then, and Load_Data changes have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted with no partial completion.
  - Frame_End is never asserted for the aborted frame.
  - The block is ready the cycle after Rst deasserts.
- Frame_Start and Frame_End are never both high (guaranteed by WIDTH >= 2).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured word) is sent in a PARITY state after the last data bit. Frame length is WIDTH+1 cycles.
  - Frame_End and Load_Ready move to the parity cycle.
  - Parity is computed at accept from Load_Data and held in a register.
- Undefined: no PARITY state and no parity register; frame length is WIDTH cycles.

Decomposition:
- Shared package piso_pkg holds:
  - state encoding constants ST_IDLE, ST_SHIFT, ST_PARITY;
  - the default WIDTH constant shared with the receiving deserializer.
- One natural sub-module: piso_bit_counter, a parameterized up-counter with clear, enable and terminal-count flag.

Test Plan:
- Single frame: WIDTH=8, accept 8'hA5 at edge k -> Data_Out = 1,0,1,0,0,1,0,1 on cycles k+1..k+8; Frame_Start only at k+1; Frame_End only at k+8; Data_Valid = 0 and Data_Out = IDLE_LEVEL at k+9.
- Back-to-back: Load_Valid held with 8'hA5 then 8'h3C -> 16 consecutive Data_Valid cycles with stream 10100101 00111100; second Frame_Start at k+9.
- Busy hold-off: Load_Valid = 1 with 8'hFF during cycles k+2..k+7 of an 8'h00 frame -> Load_Ready = 0, stream stays all zeros, 8'hFF is accepted only at the final-cycle edge.
- Reset mid-frame: Rst for 1 cycle after 3 bits of 8'hA5 -> next cycle Data_Valid = 0, no Frame_End; a new 8'h81 frame then transmits 10000001 cleanly.
- Idle level: IDLE_LEVEL=1, no load for 5 cycles after reset -> Data_Out = 1 and Data_Valid = 0 throughout.
- Parity (PISO_PARITY_EN): 8'hA5 -> ninth bit 0; 8'h07 -> ninth bit 1; Frame_End on the ninth cycle; back-to-back frames are 9 cycles apart.
